// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB master bridge.
package apb_pkg;

    // Bridge sequencing states: idle, APB setup phase, APB access phase,
    // and the single response cycle towards the core.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef logic [31:0] apb_word_t;

    // Slave i lives at APB_BASE + i * (1 << SLAVE_STRIDE_LOG2).
    localparam apb_word_t APB_BASE          = 32'h1000_0000;
    localparam int        SLAVE_STRIDE_LOG2 = 12;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB bus bundle between the bridge (master) and its peripherals (slave).
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int N_SLAVES = 4
);
    apb_word_t           PADDR;
    logic                PWRITE;
    logic                PENABLE;
    apb_word_t           PWDATA;
    logic [N_SLAVES-1:0] PSEL;
    apb_word_t           PRDATA [N_SLAVES];
    logic [N_SLAVES-1:0] PREADY;

    modport master (
        output PADDR,
        output PWRITE,
        output PENABLE,
        output PWDATA,
        output PSEL,
        input  PRDATA,
        input  PREADY
    );

    modport slave (
        input  PADDR,
        input  PWRITE,
        input  PENABLE,
        input  PWDATA,
        input  PSEL,
        output PRDATA,
        output PREADY
    );
endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder: maps a byte address onto one of
// N_SLAVES 4 KiB windows starting at APB_BASE.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int N_SLAVES = 4
) (
    input  apb_word_t           addr,
    output logic                hit,
    output logic [N_SLAVES-1:0] sel
);
    localparam int PAGE_W = 32 - SLAVE_STRIDE_LOG2;

    logic [PAGE_W-1:0] page_off;
    // The byte offset inside a window belongs to the slave, not the decoder.
    logic              unused_low_bits;

    assign unused_low_bits = ^addr[SLAVE_STRIDE_LOG2-1:0];

    // Window offset relative to APB_BASE; wrap-around makes addresses below
    // the base look huge, so a single unsigned compare covers both ends.
    always_comb begin
        page_off = addr[31:SLAVE_STRIDE_LOG2] - APB_BASE[31:SLAVE_STRIDE_LOG2];
        hit      = (page_off < PAGE_W'(N_SLAVES));
        sel      = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (hit && (page_off == PAGE_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Bridges the core's single-request data port onto the APB bus: sequences
// SETUP/ACCESS, waits on the selected slave's PREADY with a timeout, and
// hands back read data with a one-cycle ready/err strobe.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                transfer,
    input  logic                write,
    input  apb_word_t           addr,
    input  apb_word_t           wdata,
    output apb_word_t           rdata,
    output logic                ready,
    output logic                err,
    apb_master_bridge_if.master apb
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    apb_state_t          state_q;
    apb_state_t          state_d;

    // Request registers; PADDR/PWDATA/PWRITE are driven straight from these
    // so they keep their last value while the bus is idle.
    apb_word_t           paddr_q;
    apb_word_t           pwdata_q;
    logic                pwrite_q;
    logic [N_SLAVES-1:0] sel_q;

    // Response registers, presented to the core only during RESP.
    apb_word_t           rdata_q;
    logic                err_q;

    logic [7:0]          wait_q;
    logic [7:0]          wait_inc;

    logic                dec_hit;
    logic [N_SLAVES-1:0] dec_sel;

    logic                latch_req;
    logic                clr_wait;
    logic                inc_wait;
    logic                cap_rsp;
    logic                rsp_err;
    apb_word_t           rsp_rdata;

    logic                slave_ready;
    apb_word_t           slave_rdata;

    apb_addr_decoder #(
        .N_SLAVES (N_SLAVES)
    ) u_addr_decoder (
        .addr (addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign wait_inc = wait_q + 8'd1;

    // Observe only the latched slave's PREADY/PRDATA; every other slave is masked.
    always_comb begin
        slave_ready = 1'b0;
        slave_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            slave_ready = slave_ready | (apb.PREADY[i] & sel_q[i]);
            slave_rdata = slave_rdata | (apb.PRDATA[i] & {32{sel_q[i]}});
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, datapath enables and bus/core outputs.
    always_comb begin
        state_d     = state_q;
        latch_req   = 1'b0;
        clr_wait    = 1'b0;
        inc_wait    = 1'b0;
        cap_rsp     = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;

        apb.PSEL    = '0;
        apb.PENABLE = 1'b0;
        ready       = 1'b0;
        err         = 1'b0;
        rdata       = '0;

        case (state_q)
            IDLE: begin
                if (transfer) begin
                    latch_req = 1'b1;
                    if (dec_hit) begin
                        clr_wait = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        // Decode miss never touches the bus.
                        cap_rsp = 1'b1;
                        rsp_err = 1'b1;
                        state_d = RESP;
                    end
                end
            end

            SETUP: begin
                apb.PSEL = sel_q;
                state_d  = ACCESS;
            end

            ACCESS: begin
                apb.PSEL    = sel_q;
                apb.PENABLE = 1'b1;
                if (slave_ready) begin
                    // A late PREADY still wins over a timeout in the same cycle.
                    cap_rsp   = 1'b1;
                    rsp_rdata = pwrite_q ? '0 : slave_rdata;
                    state_d   = RESP;
                end else if (wait_inc == TIMEOUT_CNT) begin
                    cap_rsp = 1'b1;
                    rsp_err = 1'b1;
                    state_d = RESP;
                end else begin
                    inc_wait = 1'b1;
                end
            end

            RESP: begin
                ready   = 1'b1;
                err     = err_q;
                rdata   = rdata_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response capture.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            sel_q    <= '0;
            wait_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (latch_req) begin
                paddr_q  <= addr;
                pwdata_q <= wdata;
                pwrite_q <= write;
                sel_q    <= dec_sel;
            end
            if (clr_wait) begin
                wait_q <= '0;
            end else if (inc_wait) begin
                wait_q <= wait_inc;
            end
            if (cap_rsp) begin
                rdata_q <= rsp_rdata;
                err_q   <= rsp_err;
            end
        end
    end

    assign apb.PADDR  = paddr_q;
    assign apb.PWDATA = pwdata_q;
    assign apb.PWRITE = pwrite_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_apb_master_bridge;
    localparam int          N    = 4;
    localparam int          TO   = 255;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] TOP  = BASE + N * 32'h1000;

    logic        PCLK;
    logic        PRESET;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    apb_master_bridge_if #(.N_SLAVES(N)) bus ();

    apb_master_bridge #(
        .N_SLAVES (N),
        .TIMEOUT  (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .apb      (bus.master)
    );

    int checks = 0;
    int errors = 0;

    // Slave responders: slave i raises PREADY after lat_cfg[i] wait cycles of
    // ACCESS; unselected slaves drive arbitrary noise on PREADY.
    int          lat_cfg [N];
    logic [31:0] prd_cfg [N];
    logic [N-1:0] noise;
    int          acc_cnt = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.PRDATA[i] = prd_cfg[i];
            bus.PREADY[i] = bus.PSEL[i] ? (bus.PENABLE && (acc_cnt >= lat_cfg[i])) : noise[i];
        end
    end

    // Observations from the last transaction.
    int          r_lat;
    logic        r_err;
    logic [31:0] r_rd;
    logic [N-1:0] r_psel;
    logic [N-1:0] r_psel_first;
    logic [N-1:0] r_psel_at_rdy;
    logic        r_pen_at_rdy;
    int          r_pen;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;

    // Issues one request and records what the bus and core port showed.
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        transfer = 1'b1;
        write    = w;
        addr     = a;
        wdata    = d;
        r_lat = -1; r_err = 1'bx; r_rd = 'x; r_psel = '0; r_psel_first = '0;
        r_psel_at_rdy = 'x; r_pen_at_rdy = 1'bx; r_pen = 0;
        r_paddr = '0; r_pwdata = '0; r_pwrite = 1'b0;
        for (int c = 1; c <= 400 && r_lat < 0; c++) begin
            @(negedge PCLK);
            transfer = 1'b0;
            if (c == 1) r_psel_first = bus.PSEL;
            r_psel = r_psel | bus.PSEL;
            if (bus.PENABLE) r_pen++;
            if (bus.PSEL != '0) begin
                r_paddr  = bus.PADDR;
                r_pwdata = bus.PWDATA;
                r_pwrite = bus.PWRITE;
            end
            if (ready) begin
                r_lat         = c;
                r_err         = err;
                r_rd          = rdata;
                r_psel_at_rdy = bus.PSEL;
                r_pen_at_rdy  = bus.PENABLE;
            end
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (bus.PSEL !== '0) begin errors++; $display("FAIL reset_psel got %b want 0", bus.PSEL); end
        checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable got %b want 0", bus.PENABLE); end
        checks++; if (bus.PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h want 0", bus.PADDR); end
        checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h want 0", bus.PWDATA); end
        checks++; if (bus.PWRITE !== 1'b0) begin errors++; $display("FAIL reset_pwrite got %b want 0", bus.PWRITE); end
        PRESET = 1'b1;
    endtask

    task automatic test_write_registered();
        lat_cfg[0] = 1;
        prd_cfg[0] = 32'hDEAD_BEEF;
        run_xfer(1'b1, 32'h1000_0000, 32'h0000_00FF);
        checks++; if (r_lat !== 4) begin errors++; $display("FAIL wr_latency got %0d want 4", r_lat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", r_err); end
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", r_rd); end
        checks++; if (r_psel_first !== 4'b0001) begin errors++; $display("FAIL wr_psel_t1 got %b want 0001", r_psel_first); end
        checks++; if (r_pen !== 2) begin errors++; $display("FAIL wr_penable_cycles got %0d want 2", r_pen); end
        checks++; if (r_pwdata !== 32'h0000_00FF) begin errors++; $display("FAIL wr_pwdata got %h want 000000ff", r_pwdata); end
        checks++; if (r_pwrite !== 1'b1) begin errors++; $display("FAIL wr_pwrite got %b want 1", r_pwrite); end
        checks++; if (r_psel_at_rdy !== 4'b0000) begin errors++; $display("FAIL wr_psel_at_ready got %b want 0000", r_psel_at_rdy); end
        checks++; if (r_pen_at_rdy !== 1'b0) begin errors++; $display("FAIL wr_penable_at_ready got %b want 0", r_pen_at_rdy); end
    endtask

    task automatic test_read_zero_wait();
        lat_cfg[2] = 0;
        prd_cfg[2] = 32'h0000_005A;
        run_xfer(1'b0, 32'h1000_2008, 32'h1234_5678);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", r_lat); end
        checks++; if (r_rd !== 32'h0000_005A) begin errors++; $display("FAIL rd_rdata got %h want 0000005a", r_rd); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", r_err); end
        checks++; if (r_psel !== 4'b0100) begin errors++; $display("FAIL rd_psel got %b want 0100", r_psel); end
        checks++; if (r_paddr !== 32'h1000_2008) begin errors++; $display("FAIL rd_paddr got %h want 10002008", r_paddr); end
        checks++; if (r_pwrite !== 1'b0) begin errors++; $display("FAIL rd_pwrite got %b want 0", r_pwrite); end
        lat_cfg[3] = 0;
        prd_cfg[3] = 32'hCAFE_0003;
        run_xfer(1'b0, 32'h1000_3FFC, 32'h0);
        checks++; if (r_rd !== 32'hCAFE_0003) begin errors++; $display("FAIL rd_last_slave_rdata got %h want cafe0003", r_rd); end
        checks++; if (r_psel !== 4'b1000) begin errors++; $display("FAIL rd_last_slave_psel got %b want 1000", r_psel); end
    endtask

    task automatic test_decode_miss();
        run_xfer(1'b0, 32'h1000_5000, 32'h0);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL miss_latency got %0d want 1", r_lat); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL miss_err got %b want 1", r_err); end
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL miss_rdata got %h want 0", r_rd); end
        checks++; if (r_psel !== 4'b0000) begin errors++; $display("FAIL miss_psel got %b want 0000", r_psel); end
        run_xfer(1'b1, 32'h0FFF_FFFC, 32'h5555_AAAA);
        checks++; if (r_lat !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL miss_below_base got lat %0d err %b want lat 1 err 1", r_lat, r_err); end
        run_xfer(1'b0, 32'h1000_4000, 32'h0);
        checks++; if (r_lat !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL miss_first_above got lat %0d err %b want lat 1 err 1", r_lat, r_err); end
    endtask

    task automatic test_timeout();
        lat_cfg[1] = 1000;
        prd_cfg[1] = 32'h1111_2222;
        run_xfer(1'b0, 32'h1000_1004, 32'h0);
        checks++; if (r_pen !== TO) begin errors++; $display("FAIL to_penable_cycles got %0d want %0d", r_pen, TO); end
        checks++; if (r_lat !== TO + 2) begin errors++; $display("FAIL to_latency got %0d want %0d", r_lat, TO + 2); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", r_err); end
        checks++; if (r_rd !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", r_rd); end
        checks++; if (r_psel_at_rdy !== 4'b0000 || r_pen_at_rdy !== 1'b0) begin errors++; $display("FAIL to_bus_drop got psel %b pen %b want 0000 0", r_psel_at_rdy, r_pen_at_rdy); end
        // PREADY on the very last permitted ACCESS cycle still succeeds.
        lat_cfg[1] = TO - 1;
        run_xfer(1'b0, 32'h1000_1000, 32'h0);
        checks++; if (r_lat !== TO + 2 || r_err !== 1'b0) begin errors++; $display("FAIL to_edge_ok got lat %0d err %b want lat %0d err 0", r_lat, r_err, TO + 2); end
        checks++; if (r_rd !== 32'h1111_2222) begin errors++; $display("FAIL to_edge_rdata got %h want 11112222", r_rd); end
        lat_cfg[1] = TO;
        run_xfer(1'b0, 32'h1000_1000, 32'h0);
        checks++; if (r_lat !== TO + 2 || r_err !== 1'b1) begin errors++; $display("FAIL to_edge_late got lat %0d err %b want lat %0d err 1", r_lat, r_err, TO + 2); end
    endtask

    task automatic test_reset_mid_transfer();
        int pulses;
        lat_cfg[1] = 1000;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000; wdata = 32'h0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        checks++; if (bus.PENABLE !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access got %b want 1", bus.PENABLE); end
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++; if (bus.PSEL !== '0) begin errors++; $display("FAIL rst_mid_psel got %b want 0000", bus.PSEL); end
        checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_mid_penable got %b want 0", bus.PENABLE); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", ready); end
        PRESET = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (ready || bus.PSEL != '0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d want 0", pulses); end
        lat_cfg[1] = 0;
        prd_cfg[1] = 32'h0BAD_F00D;
        run_xfer(1'b0, 32'h1000_1010, 32'h0);
        checks++; if (r_lat !== 3 || r_err !== 1'b0 || r_rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_mid_followup got lat %0d err %b rdata %h want 3 0 0badf00d", r_lat, r_err, r_rd); end
    endtask

    task automatic test_back_to_back();
        int    setups;
        int    readies;
        bit    strobed;
        logic [31:0] rd_seen;
        lat_cfg[3] = 2;
        prd_cfg[3] = 32'h3333_0303;
        lat_cfg[0] = 0;
        setups = 0; readies = 0; strobed = 0; rd_seen = '0;
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3010; wdata = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge PCLK);
            transfer = 1'b0;
            if (bus.PSEL != '0 && !bus.PENABLE) setups++;
            if (ready) begin
                readies++;
                rd_seen = rdata;
            end
            if (bus.PENABLE && !strobed) begin
                transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h7777_7777;
                strobed = 1;
            end
            if (ready) begin
                transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h8888_8888;
            end
        end
        transfer = 1'b0;
        checks++; if (setups !== 1) begin errors++; $display("FAIL b2b_setups got %0d want 1", setups); end
        checks++; if (readies !== 1) begin errors++; $display("FAIL b2b_readies got %0d want 1", readies); end
        checks++; if (rd_seen !== 32'h3333_0303) begin errors++; $display("FAIL b2b_rdata got %h want 33330303", rd_seen); end
        checks++; if (bus.PADDR !== 32'h1000_3010) begin errors++; $display("FAIL b2b_paddr_held got %h want 10003010", bus.PADDR); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, exp_rd;
        logic        w, exp_err, hit;
        logic [N-1:0] exp_psel;
        int          s, r, exp_lat, exp_pen;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                prd_cfg[i] = $urandom;
                r = $urandom_range(0, 19);
                lat_cfg[i] = (r < 19) ? (r % 4) : 300;
            end
            noise = N'($urandom);
            s = $urandom_range(0, N + 1);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + 32'(s) * 32'h1000 + 32'($urandom_range(0, 4095));
            w = 1'($urandom_range(0, 1));
            d = $urandom;

            hit = (a >= BASE) && (a < TOP);
            exp_psel = '0;
            if (!hit) begin
                exp_lat = 1; exp_err = 1'b1; exp_rd = '0; exp_pen = 0;
            end else begin
                s = int'((a - BASE) / 32'h1000);
                exp_psel[s] = 1'b1;
                if (lat_cfg[s] < TO) begin
                    exp_lat = 3 + lat_cfg[s]; exp_err = 1'b0;
                    exp_rd  = w ? 32'h0 : prd_cfg[s]; exp_pen = lat_cfg[s] + 1;
                end else begin
                    exp_lat = 2 + TO; exp_err = 1'b1; exp_rd = '0; exp_pen = TO;
                end
            end

            run_xfer(w, a, d);
            checks++; if (r_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency addr %h got %0d want %0d", t, a, r_lat, exp_lat); end
            checks++; if (r_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err addr %h got %b want %b", t, a, r_err, exp_err); end
            checks++; if (r_rd !== exp_rd) begin errors++; $display("FAIL rnd%0d_rdata addr %h got %h want %h", t, a, r_rd, exp_rd); end
            checks++; if (r_psel !== exp_psel) begin errors++; $display("FAIL rnd%0d_psel addr %h got %b want %b", t, a, r_psel, exp_psel); end
            checks++; if (r_pen !== exp_pen) begin errors++; $display("FAIL rnd%0d_penable addr %h got %0d want %0d", t, a, r_pen, exp_pen); end
            if (hit) begin
                checks++; if (r_paddr !== a || r_pwdata !== d || r_pwrite !== w) begin
                    errors++;
                    $display("FAIL rnd%0d_bus got %h/%h/%b want %h/%h/%b", t, r_paddr, r_pwdata, r_pwrite, a, d, w);
                end
            end
        end
        noise = '0;
    endtask

    initial begin
        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        noise    = '0;
        for (int i = 0; i < N; i++) begin
            lat_cfg[i] = 0;
            prd_cfg[i] = '0;
        end
        test_reset();
        test_write_registered();
        test_read_zero_wait();
        test_decode_miss();
        test_timeout();
        test_reset_mid_transfer();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Bridges the RV32I core's data-memory request port to the APB peripheral bus.
- Drives PADDR/PWDATA/PWRITE/PENABLE and one-hot PSEL to up to N_SLAVES peripherals (GPIO, UART, ...).
- Sequences the APB SETUP/ACCESS phases, waits on the selected slave's PREADY, and returns read data plus a done/error strobe to the core.
- Sits directly upstream of every APB slave, including the GPIO peripheral.

Parameters:
- N_SLAVES, 4, number of APB slaves; slave i occupies APB_BASE + i*0x1000.
- TIMEOUT, 255, max ACCESS cycles waited for PREADY before aborting with error; range 1..255.

Ports:
- PCLK  in  1  bus clock, rising edge.
- PRESET  in  1  synchronous, active-low reset.
- transfer  in  1  one-cycle request strobe from core.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  32  byte address; sampled with transfer.
- wdata  in  32  write data; sampled with transfer.
- rdata  out  32  read data; valid while ready = 1.
- ready  out  1  one-cycle completion strobe.
- err  out  1  qualifies ready: decode miss or timeout.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PWDATA  out  32  APB write data.
- PSEL  out  N_SLAVES  one-hot slave select.
- PRDATA  in  N_SLAVES x 32  per-slave read data (unpacked array).
- PREADY  in  N_SLAVES  per-slave ready.

Behaviour:
- Clock and reset: one clock, PCLK; reset is synchronous and active-low (PRESET).
- Reset values: state IDLE; all outputs 0.
- Reset mid-transfer: at the next PCLK edge with PRESET = 0, drop PSEL/PENABLE, return to IDLE, no ready pulse.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - transfer = 1 latches addr/wdata/write into PADDR/PWDATA/PWRITE and runs the address decoder.
  - Hit: next state SETUP; PSEL[idx] = 1, PENABLE = 0 in SETUP.
  - Miss: next state RESP with err = 1.
  - transfer = 0: PSEL = 0, PENABLE = 0; PADDR/PWDATA/PWRITE hold their last values.
- Decode: hit iff addr[31:12] - APB_BASE[31:12] < N_SLAVES; idx = addr[15:12].
- SETUP: always advances to ACCESS, setting PENABLE = 1 and holding PSEL.
- ACCESS:
  - Increments wait counter (8-bit, cleared on SETUP entry).
  - PREADY[idx] = 1: capture PRDATA[idx] into rdata (writes: rdata = 0), err = 0, deassert PSEL/PENABLE, go to RESP.
  - Counter reaches TIMEOUT with PREADY[idx] still 0: rdata = 0, err = 1, deassert PSEL/PENABLE, go to RESP.
- RESP: ready = 1 for exactly one cycle (err as set), then IDLE. ready and err are 0 in all other states.
- Latency:
  - Zero-wait slave: transfer at T0, SETUP T1, ACCESS T2, ready T3.
  - GPIO-style slave (registered PREADY, one wait): ready at T4.
  - Decode miss: ready + err at T1.
- Request strobes: transfer is ignored outside IDLE, with no queueing. The core issues the next strobe no earlier than the ready cycle; a strobe during RESP is dropped.
- Only PREADY[idx] and PRDATA[idx] are observed; other slaves' outputs are ignored.
- PADDR is forwarded unmodified; the slave decodes its low bits.

Decomposition:
- Package apb_pkg holds:
  - enum apb_state_t {IDLE, SETUP, ACCESS, RESP};
  - APB_BASE = 32'h1000_0000;
  - SLAVE_STRIDE_LOG2 = 12;
  - typedef apb_word_t = logic [31:0].
- One combinational sub-module, apb_addr_decoder: addr in; hit and one-hot sel out.

Test Plan:
- Write 0x0000_00FF to 0x1000_0000, slave 0 with registered PREADY: PSEL[0] = 1 from T1; PENABLE = 1 at T2–T3; PWDATA = 0x0000_00FF; ready = 1, err = 0 at T4; PSEL = 0 at T4.
- Read 0x1000_2008, slave 2 zero-wait, PRDATA[2] = 0x0000_005A: PSEL = 4'b0100; ready at T3 with rdata = 0x5A, err = 0.
- Read 0x1000_5000 with N_SLAVES = 4: no PSEL activity; ready = 1, err = 1, rdata = 0 at T1.
- Slave 1 holds PREADY = 0, TIMEOUT = 255: PENABLE high for 255 cycles, then PSEL/PENABLE drop; ready = 1, err = 1, rdata = 0.
- PRESET = 0 for one cycle during ACCESS: next cycle PSEL = 0, PENABLE = 0, ready = 0, state IDLE; a following transfer completes normally.
- Second transfer strobe during ACCESS is ignored: only one SETUP/ACCESS sequence and one ready pulse are observed.
